// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a byte FIFO read port and packs BYTES consecutive
//   entries into one DATA_W*BYTES word, presented on a valid/ready stream.
// Latency: a byte lands one cycle after its read; a full word reaches the
//   output one cycle after its last byte lands (one bubble per word).
// Backpressure: a full assembly word with a busy output slot stalls FIFO reads.
//   Buffering is one assembly word plus one output word, and no byte is dropped.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset (0 = in reset)
//   fifo_empty           FIFO empty flag
//   fifo_rd_en           FIFO read strobe, never high while fifo_empty=1
//   fifo_data            FIFO data_out, valid one cycle after an accepted read
//   out_data/out_valid   packed word stream, first byte in the low lane
//   out_ready            consumer accepts the word
//   words_out            count of completed output handshakes (wraps)
// Optional build macro PACK_FLUSH_EN adds:
//   flush                pulse: emit the partial word once in-flight data has landed
//   out_bytes            number of valid lanes in out_data (BYTES for full words).
//                        It is 3 bits wide, so with BYTES=8 a full word reads 0.
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic [DATA_W-1:0]         fifo_data,
  output logic [DATA_W*BYTES-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          words_out
`ifdef PACK_FLUSH_EN
  ,
  input  logic                      flush,
  output logic [2:0]                out_bytes
`endif
);

  localparam int            CW     = $clog2(BYTES + 1);
  localparam int            WW     = DATA_W * BYTES;
  localparam logic [CW-1:0] FULL   = CW'(BYTES);
  localparam logic [CW:0]   FULL_X = (CW + 1)'(BYTES);

  logic [CW-1:0] cnt;        // bytes already landed in the assembly register
  logic          infl;       // a read was accepted last cycle; its byte lands now
  logic [WW-1:0] asm_q;      // assembly register
  logic [CW:0]   occ;
  logic [CW-1:0] lane;
  logic [WW-1:0] load_word;
  logic          slot_free;
  logic          xfer;
  logic          flush_emit;
  logic          load;
  logic          rd_block;
  logic          rd_ok;

  assign slot_free = !out_valid || out_ready;
  assign xfer      = (cnt == FULL) && slot_free;
  // Count the in-flight byte as occupied so a read is never issued without
  // a lane to land in.
  assign occ       = {1'b0, cnt} + {{CW{1'b0}}, infl};
  assign rd_ok     = (occ < FULL_X) || xfer;

`ifdef PACK_FLUSH_EN
  logic flush_pend;

  // Reads stop from the flush pulse onward so the partial word cannot grow.
  assign rd_block   = flush || flush_pend;
  // A full word is handled by the normal xfer path.
  assign flush_emit = flush_pend && !infl && (cnt != '0) && (cnt != FULL) && slot_free;
`else
  assign rd_block   = 1'b0;
  assign flush_emit = 1'b0;
`endif

  assign load       = xfer || flush_emit;
  assign fifo_rd_en = rst && !fifo_empty && !rd_block && rd_ok;

  // A byte landing in the same cycle as a word load starts the next word.
  assign lane = load ? '0 : cnt;

  // Lanes at or above cnt are stale, so zero them. For a full word none are.
  always_comb begin
    load_word = asm_q;
    for (int i = 0; i < BYTES; i++) begin
      if (i >= int'(cnt)) begin
        load_word[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      infl      <= 1'b0;
      asm_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      words_out <= '0;
    end else begin
      infl <= fifo_rd_en;

      if (infl) begin
        for (int i = 0; i < BYTES; i++) begin
          if (i == int'(lane)) begin
            asm_q[i*DATA_W +: DATA_W] <= fifo_data;
          end
        end
      end

      if (load) begin
        cnt <= infl ? CW'(1) : '0;
      end else if (infl) begin
        cnt <= cnt + CW'(1);
      end

      if (load) begin
        out_data  <= load_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) begin
        words_out <= words_out + CNT_W'(1);
      end
    end
  end

`ifdef PACK_FLUSH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
      out_bytes  <= '0;
    end else begin
      // An empty assembly register with nothing in flight ends the flush quietly.
      if (flush) begin
        flush_pend <= 1'b1;
      end else if (flush_emit || (!infl && (cnt == '0))) begin
        flush_pend <= 1'b0;
      end

      if (xfer) begin
        out_bytes <= 3'(BYTES);
      end else if (flush_emit) begin
        out_bytes <= 3'(cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en, fifo_rd_en_w;
  logic [7:0]  fifo_data = 8'h00;
  logic [31:0] out_data, out_data_w;
  logic        out_valid, out_valid_w;
  logic        out_ready = 1'b1;
  logic [15:0] words_out;
  logic [3:0]  words_w;
`ifdef PACK_FLUSH_EN
  logic        flush = 1'b0;
  logic [2:0]  out_bytes, out_bytes_w;
`endif

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_W(8), .BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .words_out(words_out)
`ifdef PACK_FLUSH_EN
    , .flush(flush), .out_bytes(out_bytes)
`endif
  );

  // Twin with a 4-bit word counter, fed the same inputs, to see the wrap.
  fifo_rd_packer #(.DATA_W(8), .BYTES(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_w),
    .fifo_data(fifo_data), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .words_out(words_w)
`ifdef PACK_FLUSH_EN
    , .flush(flush), .out_bytes(out_bytes_w)
`endif
  );

  // FIFO model: one-cycle read latency.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitors
  int cyc = 0, rd_pulses = 0, rd_viol = 0, vcnt = 0, stab_err = 0, twin_err = 0, ncap = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;
  logic [31:0] caps [0:255];
  int          cap_cyc [0:255];
`ifdef PACK_FLUSH_EN
  logic [2:0]  cap_bytes [0:255];
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    if (out_valid) vcnt <= vcnt + 1;
    if (rst && pv && !pr && (out_data !== pd)) stab_err <= stab_err + 1;
    if ((fifo_rd_en_w !== fifo_rd_en) || (out_valid_w !== out_valid) || (out_data_w !== out_data))
      twin_err <= twin_err + 1;
    pv <= rst && out_valid;
    pr <= out_ready;
    pd <= out_data;
    if (out_valid && out_ready) begin
      caps[ncap[7:0]]    <= out_data;
      cap_cyc[ncap[7:0]] <= cyc;
`ifdef PACK_FLUSH_EN
      cap_bytes[ncap[7:0]] <= out_bytes;
`endif
      ncap <= ncap + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_caps(input int target, input int budget, input string name);
    int n = 0;
    while (ncap < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(ncap), 64'(target));
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [5];
    int   b_rd, b_v, b_c, bad, exp_words;
    logic [31:0] e;

    vt[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vt[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
    vt[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412};
    vt[3] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F0180};
    vt[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
    exp_words = 0;

    // Reset state, with data already waiting in the FIFO.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_words", 64'(words_out), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
`ifdef PACK_FLUSH_EN
    check("rst_out_bytes", 64'(out_bytes), 64'd0);
`endif

    // Single word.
    b_rd = rd_pulses; b_v = vcnt; b_c = ncap;
    rst = 1'b1;
    wait_caps(b_c + 1, 20, "t1_wait");
    repeat (3) @(negedge clk);
    check("t1_word", 64'(caps[b_c]), 64'h44332211);
    check("t1_valid_cycles", 64'(vcnt - b_v), 64'd1);
    check("t1_rd_pulses", 64'(rd_pulses - b_rd), 64'd4);
    exp_words += 1;
    check("t1_words", 64'(words_out), 64'(exp_words));

    // Backpressure: two words buffered, reads stall after 8 bytes.
    out_ready = 1'b0;
    b_rd = rd_pulses; b_c = ncap;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (20) @(negedge clk);
    check("t2_valid_held", 64'(out_valid), 64'd1);
    check("t2_data_held", 64'(out_data), 64'h04030201);
    check("t2_rd_stall", 64'(rd_pulses - b_rd), 64'd8);
    check("t2_no_handshake", 64'(ncap - b_c), 64'd0);
    out_ready = 1'b1;
    wait_caps(b_c + 2, 10, "t2_wait");
    check("t2_word0", 64'(caps[b_c]), 64'h04030201);
    check("t2_word1", 64'(caps[b_c + 1]), 64'h08070605);
    check("t2_back_to_back", 64'(cap_cyc[b_c + 1] - cap_cyc[b_c]), 64'd1);
    @(negedge clk);
    exp_words += 2;
    check("t2_words", 64'(words_out), 64'(exp_words));

    // FIFO runs dry mid-word.
    repeat (3) @(negedge clk);
    b_rd = rd_pulses; b_v = vcnt; b_c = ncap;
    push(8'hA1); push(8'hA2);
    repeat (10) @(negedge clk);
    check("t3_rd_partial", 64'(rd_pulses - b_rd), 64'd2);
    check("t3_no_valid", 64'(vcnt - b_v), 64'd0);
    push(8'hA3); push(8'hA4);
    wait_caps(b_c + 1, 20, "t3_wait");
    check("t3_word", 64'(caps[b_c]), 64'hA4A3A2A1);
    check("t3_rd_total", 64'(rd_pulses - b_rd), 64'd4);
    exp_words += 1;

    // Table-driven words, streamed back to back.
    repeat (3) @(negedge clk);
    b_c = ncap;
    for (int v = 0; v < 5; v++) begin
      push(vt[v].b0); push(vt[v].b1); push(vt[v].b2); push(vt[v].b3);
    end
    wait_caps(b_c + 5, 60, "tab_wait");
    for (int v = 0; v < 5; v++) begin
      check($sformatf("tab_word%0d", v), 64'(caps[b_c + v]), 64'(vt[v].exp));
      if (v > 0) check($sformatf("tab_spacing%0d", v), 64'(cap_cyc[b_c + v] - cap_cyc[b_c + v - 1]), 64'd5);
    end
    exp_words += 5;

    // 400-byte stream: 4 reads per 5 cycles, last read on the 499th edge.
    repeat (3) @(negedge clk);
    b_rd = rd_pulses; b_c = ncap;
    for (int i = 0; i < 400; i++) push(8'(i));
    repeat (498) @(negedge clk);
    check("s_rd_498", 64'(rd_pulses - b_rd), 64'd399);
    @(negedge clk);
    check("s_rd_499", 64'(rd_pulses - b_rd), 64'd400);
    wait_caps(b_c + 100, 20, "s_wait");
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      e = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
      if (caps[b_c + k] !== e) bad++;
    end
    check("s_bad_words", 64'(bad), 64'd0);
    @(negedge clk);
    exp_words += 100;
    check("s_words", 64'(words_out), 64'(exp_words));
    check("s_words_wrap", 64'(words_w), 64'(exp_words % 16));

    // Asynchronous reset with cnt=3 and one byte in flight.
    repeat (3) @(negedge clk);
    b_rd = rd_pulses; b_c = ncap;
    for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
    repeat (4) @(negedge clk);
    check("ar_rd_before", 64'(rd_pulses - b_rd), 64'd4);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data", 64'(out_data), 64'd0);
    check("ar_words", 64'(words_out), 64'd0);
    check("ar_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_caps(b_c + 1, 20, "ar_wait");
    check("ar_fresh_word", 64'(caps[b_c]), 64'h58575655);
    @(negedge clk);
    exp_words = 1;
    check("ar_words_after", 64'(words_out), 64'(exp_words));

`ifdef PACK_FLUSH_EN
    // Partial-word flush, then flush with nothing assembled.
    repeat (3) @(negedge clk);
    b_c = ncap;
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (6) @(negedge clk);
    check("f_no_word_yet", 64'(ncap - b_c), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_caps(b_c + 1, 10, "f_wait");
    check("f_word", 64'(caps[b_c]), 64'h00CCBBAA);
    check("f_bytes", 64'(cap_bytes[b_c]), 64'd3);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (10) @(negedge clk);
    check("f_empty_flush", 64'(ncap - b_c), 64'd1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_caps(b_c + 2, 20, "f_full_wait");
    check("f_full_word", 64'(caps[b_c + 1]), 64'h04030201);
    check("f_full_bytes", 64'(cap_bytes[b_c + 1]), 64'd4);
`endif

    repeat (3) @(negedge clk);
    check("rd_while_empty", 64'(rd_viol), 64'd0);
    check("out_data_stable", 64'(stab_err), 64'd0);
    check("twin_agree", 64'(twin_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of the byte FIFO.
- Drains the FIFO read port (rd_en/empty/data_out) and packs BYTES consecutive bytes into one wide word.
- Presents each word on a valid/ready output stream to the next stage.
- Keeps the FIFO read-protocol rules so the FIFO never underflows.

Parameters:
- DATA_W, 8, width of one FIFO entry.
- BYTES, 4, FIFO entries per output word. Legal range 2..8.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset. 0 = in reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_data  in  DATA_W  FIFO data_out. Valid one cycle after an accepted read.
- out_data  out  DATA_W*BYTES  packed word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- words_out  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset, asynchronous, rst=0:
  - out_valid=0, out_data=0, words_out=0.
  - Byte count cnt=0, in-flight flag infl=0, assembly register cleared.
  - fifo_rd_en is forced to 0 combinationally while rst=0.
- FIFO read latency is exactly 1 cycle:
  - A read is accepted when fifo_rd_en=1 and fifo_empty=0.
  - infl=1 in the next cycle, and fifo_data is captured into lane cnt that cycle.
- Lane order: the first byte read goes to bits [DATA_W-1:0], the last byte to the MSB lane.
- Definitions:
  - xfer = (cnt==BYTES) and (out_valid==0 or out_ready==1).
  - occ = cnt + infl.
- Read issue: fifo_rd_en = !fifo_empty and (occ < BYTES or xfer). fifo_rd_en is never high while fifo_empty=1.
- On xfer:
  - Assembly register moves to out_data; out_valid=1; cnt returns to 0.
  - A byte landing in the same cycle goes to lane 0 and sets cnt=1.
- Output handshake:
  - A word completes when out_valid and out_ready are both 1 on a clock edge.
  - On completion words_out increments, wrapping modulo 2^CNT_W.
  - out_valid clears unless a new xfer occurs in the same cycle; back-to-back words are allowed.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Backpressure:
  - cnt==BYTES with the output slot busy stalls reads.
  - Total buffering is one output word plus one assembly word; no byte is ever dropped.
- Throughput: with out_ready held at 1 and the FIFO non-empty, BYTES bytes are consumed per BYTES+1 cycles (one bubble per word).
- Reset mid-operation: a partial word and any in-flight byte are discarded. The FIFO read is already committed, so that byte is lost by design.

Optional Feature:
- Macro: PACK_FLUSH_EN.
- When defined, two ports are added:
  - flush  in  1
  - out_bytes  out  3  number of valid lanes, 1..BYTES.
- A flush pulse is latched as pending.
- Once infl=0, cnt>0 and the output slot is free:
  - The partial word is emitted with unused upper lanes zero and out_bytes=cnt.
  - Reads are blocked from the flush pulse until the partial word is emitted.
- A pending flush with cnt=0 clears with no output.
- Full words drive out_bytes=BYTES. out_bytes resets to 0.
- When undefined: no flush or out_bytes ports exist, and partial bytes are held until the word completes.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> one word out_data=0x44332211, out_valid high 1 cycle, words_out=1, fifo_rd_en exactly 4 pulses.
- 8 bytes 0x01..0x08 with out_ready=0 for 20 cycles -> out_data=0x04030201 held stable, reads stop after 8 bytes; then out_ready=1 -> 0x08070605 follows next cycle, words_out=2.
- FIFO goes empty after 2 bytes for 10 cycles -> fifo_rd_en=0 whenever fifo_empty=1, out_valid stays 0; remaining 2 bytes later -> correct word, no duplicated byte.
- Streaming 400 bytes with out_ready=1 -> 100 words, bytes consumed in 500 cycles, words_out=100; with CNT_W=4, words_out=4 after wrap.
- rst asserted asynchronously between clock edges with cnt=3 and infl=1 -> outputs 0 immediately; next 4 bytes form a fresh word with no stale lanes.
- PACK_FLUSH_EN: 3 bytes 0xAA,0xBB,0xCC then flush -> out_data=0x00CCBBAA, out_bytes=3; flush with cnt=0 -> no word emitted.
